// File: rtl/tnn_vote_accum.sv
// tnn_vote_accum
// Vote accumulator and arg-max stage for a ternary/threshold neural network.
// Each accepted beat adds one vote per class from the neuron bits. The
// per-class counters saturate at their maximum value. After the last beat
// of a sample, the block scans the classes one per cycle, lowest index
// first. It then presents the winning class and its score until the
// consumer accepts them.

module tnn_vote_accum #(
    parameter int NUM_CLASSES = 6,
    parameter int CNT_W       = 4,
    parameter int IDX_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CLASSES-1:0] in_bits,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_class,
    output logic [CNT_W-1:0]       out_score
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt [NUM_CLASSES];
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] best_score;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] cand_score;
    logic [IDX_W-1:0] cand_idx;
    logic             beat_acc;
    logic             res_xfer;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == OUT);
    assign beat_acc  = in_valid && in_ready;
    assign res_xfer  = out_valid && out_ready;

    // Select the counter for the class under examination in this scan cycle
    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_cnt = cnt[i];
            end
        end
    end

    // Running arg-max: load at index 0, then replace only on a strictly larger count
    always_comb begin
        cand_score = best_score;
        cand_idx   = best_idx;
        if ((scan_idx == '0) || (cur_cnt > best_score)) begin
            cand_score = cur_cnt;
            cand_idx   = scan_idx;
        end
    end

    // Control FSM: collect beats, scan classes, then hold the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            scan_idx <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat_acc) begin
                        state    <= in_last ? SCAN : ACCUM;
                        scan_idx <= '0;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + IDX_W'(1);
                    if (scan_idx == LAST_IDX) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (res_xfer) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating per-class vote counters, cleared when a result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                cnt[i] <= '0;
            end
        end else if (res_xfer) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                cnt[i] <= '0;
            end
        end else if (beat_acc) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (in_bits[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Track the best class seen so far while scanning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score <= '0;
            best_idx   <= '0;
        end else if (state == SCAN) begin
            best_score <= cand_score;
            best_idx   <= cand_idx;
        end
    end

    // Capture the final winner on the last scan edge; held until the next sample finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_class <= '0;
            out_score <= '0;
        end else if ((state == SCAN) && (scan_idx == LAST_IDX)) begin
            out_class <= cand_idx;
            out_score <= cand_score;
        end
    end

endmodule

// File: doc/tnn_vote_accum.md
TNN_VOTE_ACCUM -- requirements
Module: tnn_vote_accum

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 6: number of output classes; one neuron output bit per class per beat.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of each per-class vote counter.
REQ-003 The block SHALL have parameter IDX_W, default 3: width of out_class; IDX_W >= ceil(log2(NUM_CLASSES)).
REQ-004 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: in_bits and in_last are valid.
REQ-007 Port in_ready, output, 1: block accepts a beat; a beat transfers on a rising edge with in_valid=1 and in_ready=1.
REQ-008 Port in_bits, input, NUM_CLASSES: 1-bit outputs of the threshold-neuron stage; bit i votes for class i.
REQ-009 Port in_last, input, 1: marks the final beat of a sample.
REQ-010 Port out_valid, output, 1: classification result available.
REQ-011 Port out_ready, input, 1: consumer takes the result; the result transfers on a rising edge with out_valid=1 and out_ready=1.
REQ-012 Port out_class, output, IDX_W: winning class index.
REQ-013 Port out_score, output, CNT_W: vote count of the winning class.

Function
REQ-014 The FSM SHALL have states IDLE, ACCUM, SCAN and OUT; reset state IDLE.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM and 0 in SCAN and OUT.
REQ-016 On each accepted beat, counter i SHALL increment by in_bits[i]; a counter at 2^CNT_W-1 SHALL saturate and not wrap.
REQ-017 IDLE SHALL go to ACCUM on an accepted beat with in_last=0, and to SCAN on an accepted beat with in_last=1.
REQ-018 ACCUM SHALL stay in ACCUM on an accepted beat with in_last=0 or while no beat is accepted, and go to SCAN on an accepted beat with in_last=1.
REQ-019 The in_last beat's votes SHALL be counted on the same edge that moves the FSM to SCAN.
REQ-020 SCAN SHALL examine one class per cycle, index 0 upward; best_score/best_idx SHALL load at index 0 and update only when cnt[i] > best_score (strict: ties keep the lowest index).
REQ-021 SCAN SHALL go to OUT on the edge that examines index NUM_CLASSES-1.
REQ-022 out_valid SHALL rise exactly NUM_CLASSES rising edges after the edge that accepted the in_last beat.
REQ-023 out_valid SHALL be 1 only in OUT; out_class and out_score SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-024 A result transfer SHALL clear all counters and move the FSM to IDLE on the same edge; in_ready SHALL be 1 in the next cycle.
REQ-025 in_valid during SCAN or OUT SHALL have no effect; the source holds the beat until in_ready=1.
REQ-026 An all-zero sample SHALL yield out_class=0, out_score=0.
REQ-027 out_class and out_score SHALL hold their last result outside OUT (not cleared on transfer).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, all counters, best_score, best_idx, out_class and out_score to 0, out_valid=0 and in_ready=1.
REQ-029 Reset asserted in any state, including mid-ACCUM or mid-SCAN, SHALL discard the partial sample without producing any output.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept a beat.

Verification
REQ-031 Reset: hold rst_n=0 for 3 cycles -> out_valid=0, in_ready=1, out_class=0, out_score=0.
REQ-032 Basic: beats 6'b000100, 6'b000110, 6'b100100 (last) -> out_class=2, out_score=3; out_valid rises 6 edges after the last beat is accepted.
REQ-033 Tie: beats 6'b100001, 6'b100001 (last) -> out_class=0, out_score=2.
REQ-034 Saturation: 20 beats of 6'b000001, the 20th with in_last=1 -> out_class=0, out_score=15.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in OUT -> outputs stable and in_ready=0; then out_ready=1 for 1 cycle -> next cycle in_ready=1, out_valid=0; the next sample 6'b010000 (last) -> out_class=4, out_score=1 (counters were cleared).
REQ-036 Reset mid-SCAN: pulse rst_n low during SCAN -> out_valid never asserts and the block is in IDLE with all counters 0.
